// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mem_loader
//  Purpose  : Boot-time program loader. Receives an image over a UART RX line
//             (8N1), packs little-endian 32-bit words and writes them into main
//             memory through the data write port. Holds the core in reset until
//             the whole image has been written.
//  Image    : N[7:0], N[15:8], then 4*N data bytes (byte 0 -> wdata[7:0]),
//             then (checksum build only) one XOR-of-all-data-bytes byte.
//  Ports    : clk         - system clock, rising edge
//             rst         - asynchronous active-high reset
//             uart_rx     - serial input, idle high, asynchronous to clk
//             mem_addr    - word-aligned byte address of the current write
//             mem_wdata   - 32-bit write data
//             mem_wr_mask - 4'hF while mem_wr_en, else 4'h0
//             mem_wr_en   - single-cycle write strobe
//             core_rst_n  - active-low core reset, released after the load
//             busy        - loader owns the memory write port
//             done        - sticky, load completed successfully
//             frame_err   - sticky, a byte had a stop bit sampled as 0
//             load_error  - sticky checksum mismatch (0 without checksum)
//  Options  : UART_LOADER_CHECKSUM_EN - adds the trailing checksum byte check.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_mem_loader #(
  parameter  int CLK_FREQ_MHZ = 100,
  parameter  int BAUD         = 115200,
  parameter  int MEMORY_DEPTH = 1024,
  parameter  int LOAD_BASE    = 0,
  localparam int AW           = $clog2(MEMORY_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rx,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wr_mask,
  output logic          mem_wr_en,
  output logic          core_rst_n,
  output logic          busy,
  output logic          done,
  output logic          frame_err,
  output logic          load_error
);

  localparam int CLKS_PER_BIT = (CLK_FREQ_MHZ * 1_000_000) / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [AW-1:0]    BASE_ADDR     = AW'(LOAD_BASE);
  localparam logic [AW-1:0]    WORD_STRIDE   = AW'(4);

  // --------------------------------------------------------------------------
  // RX synchroniser (plus one extra stage for falling-edge detection)
  // --------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // --------------------------------------------------------------------------
  // UART receiver FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = frame_err_q;

    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        // Edge rather than level, so a line left low after a framing error
        // does not immediately start a bogus byte.
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // Still low at mid start bit: genuine start, else a glitch.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            byte_d       = rx_shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Loader FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    LD_LEN_LO = 3'd0,
    LD_LEN_HI = 3'd1,
    LD_DATA   = 3'd2,
    LD_CSUM   = 3'd3,
    LD_FINISH = 3'd4,
    LD_DONE   = 3'd5,
    LD_ERROR  = 3'd6
  } ld_state_t;

`ifdef UART_LOADER_CHECKSUM_EN
  localparam ld_state_t LD_AFTER_DATA = LD_CSUM;
`else
  localparam ld_state_t LD_AFTER_DATA = LD_FINISH;
`endif

  ld_state_t     ld_state_q, ld_state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   word_buf_q, word_buf_d;   // lanes 0..2; lane 3 goes straight out
  logic          wr_en_q, wr_en_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-1:0] addr_q, addr_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state_q <= LD_LEN_LO;
      len_q      <= '0;
      word_cnt_q <= '0;
      lane_q     <= '0;
      word_buf_q <= '0;
      wr_en_q    <= 1'b0;
      wdata_q    <= '0;
      addr_q     <= BASE_ADDR;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      ld_state_q <= ld_state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      lane_q     <= lane_d;
      word_buf_q <= word_buf_d;
      wr_en_q    <= wr_en_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    ld_state_d = ld_state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    lane_d     = lane_q;
    word_buf_d = word_buf_q;
    wr_en_d    = 1'b0;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    // The address register points at the word being written; step it once
    // the strobe has been presented. Wraps naturally at MEMORY_DEPTH.
    if (wr_en_q) begin
      addr_d = addr_q + WORD_STRIDE;
    end

    unique case (ld_state_q)
      LD_LEN_LO: begin
        if (byte_valid_q) begin
          len_d[7:0] = byte_q;
          ld_state_d = LD_LEN_HI;
        end
      end
      LD_LEN_HI: begin
        if (byte_valid_q) begin
          len_d[15:8] = byte_q;
          ld_state_d  = ({byte_q, len_q[7:0]} == 16'd0) ? LD_AFTER_DATA : LD_DATA;
        end
      end
      LD_DATA: begin
        if (byte_valid_q) begin
          lane_d = lane_q + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_q;
`endif
          unique case (lane_q)
            2'd0: word_buf_d[7:0]   = byte_q;
            2'd1: word_buf_d[15:8]  = byte_q;
            2'd2: word_buf_d[23:16] = byte_q;
            default: begin
              wr_en_d    = 1'b1;
              wdata_d    = {byte_q, word_buf_q};
              word_cnt_d = word_cnt_q + 16'd1;
              if ((word_cnt_q + 16'd1) == len_q) begin
                ld_state_d = LD_AFTER_DATA;
              end
            end
          endcase
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      LD_CSUM: begin
        if (byte_valid_q) begin
          ld_state_d = (byte_q == csum_q) ? LD_FINISH : LD_ERROR;
        end
      end
`endif
      LD_FINISH: ld_state_d = LD_DONE;
      LD_DONE:   ld_state_d = LD_DONE;
      LD_ERROR:  ld_state_d = LD_ERROR;
      default:   ld_state_d = LD_LEN_LO;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_mask = wr_en_q ? 4'hF : 4'h0;
  assign core_rst_n  = (ld_state_q == LD_DONE);
  assign done        = (ld_state_q == LD_DONE);
  assign busy        = (ld_state_q != LD_DONE) && (ld_state_q != LD_ERROR);
  assign frame_err   = frame_err_q;

`ifdef UART_LOADER_CHECKSUM_EN
  assign load_error  = (ld_state_q == LD_ERROR);
`else
  assign load_error  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_mem_loader
//  Purpose  : Self-checking bench for uart_mem_loader. Two instances share the
//             serial line: one loads at 0x000, one at 0x3FC (address wrap).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mem_loader;

  localparam int CPB   = 8;        // 1 MHz / 125000 baud
  localparam int DEPTH = 1024;
  localparam int BASE1 = 'h3FC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;

  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  mask0, mask1;
  logic        en0, en1, crn0, crn1, busy0, busy1, done0, done1;
  logic        ferr0, ferr1, lerr0, lerr1;

  int total = 0;
  int bad   = 0;

  uart_mem_loader #(.CLK_FREQ_MHZ(1), .BAUD(125000), .MEMORY_DEPTH(DEPTH), .LOAD_BASE(0)) u_dut0 (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_wr_mask(mask0), .mem_wr_en(en0),
    .core_rst_n(crn0), .busy(busy0), .done(done0), .frame_err(ferr0), .load_error(lerr0)
  );

  uart_mem_loader #(.CLK_FREQ_MHZ(1), .BAUD(125000), .MEMORY_DEPTH(DEPTH), .LOAD_BASE(BASE1)) u_dut1 (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_wr_mask(mask1), .mem_wr_en(en1),
    .core_rst_n(crn1), .busy(busy1), .done(done1), .frame_err(ferr1), .load_error(lerr1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Write monitor, sampled on the falling edge
  logic [9:0]  oa0[$], oa1[$];
  logic [31:0] od0[$], od1[$];
  int   mask_viol   = 0;
  int   last_wr_cyc = -1;
  int   rel_cyc     = -1;
  logic crn_prev    = 1'b0;

  always @(negedge clk) begin
    if (en0) begin
      oa0.push_back(addr0);
      od0.push_back(wdata0);
      last_wr_cyc = cyc;
    end
    if (en1) begin
      oa1.push_back(addr1);
      od1.push_back(wdata1);
    end
    if ((en0 && mask0 != 4'hF) || (!en0 && mask0 != 4'h0)) mask_viol++;
    if ((en1 && mask1 != 4'hF) || (!en1 && mask1 != 4'h0)) mask_viol++;
    if (crn0 && !crn_prev && rel_cyc < 0) rel_cyc = cyc;
    crn_prev = crn0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    oa0.delete(); oa1.delete(); od0.delete(); od1.delete();
    mask_viol   = 0;
    last_wr_cyc = -1;
    rel_cyc     = -1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ":addr0"}, 32'(addr0), 32'h0);
    check({tag, ":addr1"}, 32'(addr1), 32'(BASE1));
    check({tag, ":wdata"}, wdata0 | wdata1, 32'h0);
    check({tag, ":mask"},  32'({mask0, mask1}), 32'h0);
    check({tag, ":wr_en"}, 32'({en0, en1}), 32'h0);
    check({tag, ":core_rst_n"}, 32'({crn0, crn1}), 32'h0);
    check({tag, ":busy"},  32'({busy0, busy1}), 32'h3);
    check({tag, ":done"},  32'({done0, done1}), 32'h0);
    check({tag, ":frame_err"},  32'({ferr0, ferr1}), 32'h0);
    check({tag, ":load_error"}, 32'({lerr0, lerr1}), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    tick(3);
    rst = 1'b0;
    clear_obs();
    tick(2 * CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(CPB);
    uart_rx = 1'b1;
    tick(2 * CPB);
  endtask

  // Image data bytes (without header / checksum)
  logic [7:0] img[$];

  task automatic send_header(input int n);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
  endtask

  task automatic send_payload(input bit bad_csum);
    logic [7:0] cs;
    cs = 8'h00;
    foreach (img[i]) begin
      send_byte(img[i], 1'b1);
      cs = cs ^ img[i];
    end
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (cs ^ 8'h01) : cs, 1'b1);
`else
    if (bad_csum) send_byte(cs ^ 8'h01, 1'b1);
`endif
  endtask

  // Reference model: word i = img[4i..4i+3] little-endian at base + 4i mod DEPTH
  task automatic check_load(input string tag, input int n, input bit exp_ok, input bit exp_ferr);
    logic [31:0] exp_data;
    check({tag, ":nwr0"}, 32'(oa0.size()), 32'(n));
    check({tag, ":nwr1"}, 32'(oa1.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      exp_data = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
      if (i < oa0.size()) begin
        check($sformatf("%s:addr0[%0d]", tag, i), 32'(oa0[i]), 32'((4 * i) % DEPTH));
        check($sformatf("%s:data0[%0d]", tag, i), od0[i], exp_data);
      end
      if (i < oa1.size()) begin
        check($sformatf("%s:addr1[%0d]", tag, i), 32'(oa1[i]), 32'((BASE1 + 4 * i) % DEPTH));
        check($sformatf("%s:data1[%0d]", tag, i), od1[i], exp_data);
      end
    end
    check({tag, ":done"},       32'({done0, done1}), exp_ok ? 32'h3 : 32'h0);
    check({tag, ":core_rst_n"}, 32'({crn0, crn1}),   exp_ok ? 32'h3 : 32'h0);
    check({tag, ":busy"},       32'({busy0, busy1}), 32'h0);
    check({tag, ":load_error"}, 32'({lerr0, lerr1}), exp_ok ? 32'h0 : 32'h3);
    check({tag, ":frame_err"},  32'({ferr0, ferr1}), exp_ferr ? 32'h3 : 32'h0);
    check({tag, ":mask"},       32'(mask_viol), 32'h0);
`ifndef UART_LOADER_CHECKSUM_EN
    if (n > 0) check({tag, ":release_latency"}, 32'(rel_cyc - last_wr_cyc), 32'd1);
`endif
  endtask

  task automatic random_image(input int n);
    img.delete();
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  // --------------------------------------------------------------------------
  logic [31:0] held_wdata;
  logic [9:0]  held_addr;
  int          n;

  initial begin
    // Reset state
    tick(3);
    check_reset_vals("reset");
    rst = 1'b0;
    clear_obs();
    tick(2 * CPB);

    // Two-word image; second instance wraps 0x3FC -> 0x000
    img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_header(2);
    send_payload(1'b0);
    check_load("img2", 2, 1'b1, 1'b0);

    // Bytes after completion are ignored
    held_wdata = wdata0;
    held_addr  = addr0;
    send_byte(8'hAA, 1'b1);
    check("after_done:nwr", 32'(oa0.size()), 32'd2);
    check("after_done:wdata", wdata0, held_wdata);
    check("after_done:addr", 32'(addr0), 32'(held_addr));
    check("after_done:done", 32'({done0, crn0, busy0}), 32'b110);

    // Empty image
    do_reset();
    img.delete();
    send_header(0);
    send_payload(1'b0);
    check_load("empty", 0, 1'b1, 1'b0);
    send_byte(8'hAA, 1'b1);
    check("empty_after:nwr", 32'(oa0.size()), 32'd0);
    check("empty_after:done", 32'({done0, crn0, busy0}), 32'b110);

    // Framing error byte is dropped
    do_reset();
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_header(1);
    send_byte(8'h11, 1'b0);
    check("ferr:flag", 32'(ferr0), 32'd1);
    check("ferr:busy", 32'(busy0), 32'd1);
    send_payload(1'b0);
    check_load("ferr", 1, 1'b1, 1'b1);

    // Short glitch produces no byte
    do_reset();
    random_image(1);
    send_header(1);
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(3 * CPB);
    check("glitch:nwr", 32'(oa0.size()), 32'd0);
    check("glitch:state", 32'({busy0, done0, ferr0}), 32'b100);
    send_payload(1'b0);
    check_load("glitch", 1, 1'b1, 1'b0);

    // Reset in the middle of the 3rd data byte
    do_reset();
    send_header(2);
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    uart_rx = 1'b0;
    tick(CPB);
    uart_rx = 1'b1;
    tick(3 * CPB);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    check("midrst:nwr", 32'(oa0.size()), 32'd0);
    tick(2);
    uart_rx = 1'b1;
    tick(1);
    rst = 1'b0;
    clear_obs();
    tick(2 * CPB);
    random_image(3);
    send_header(3);
    send_payload(1'b0);
    check_load("after_midrst", 3, 1'b1, 1'b0);

`ifdef UART_LOADER_CHECKSUM_EN
    // Checksum match / mismatch
    do_reset();
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_header(1);
    send_payload(1'b0);
    check_load("csum_ok", 1, 1'b1, 1'b0);
    do_reset();
    send_header(1);
    send_payload(1'b1);
    check_load("csum_bad", 1, 1'b0, 1'b0);
`endif

    // Randomized images
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 5));
      do_reset();
      random_image(n);
      send_header(n);
      send_payload(1'b0);
      check_load($sformatf("rand%0d", r), n, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
